msu_data_port: RTL and testbench

MSU_DATA_PORT -- requirements
Module: msu_data_port

---
 rtl/msu_data_port.sv | 159 +++++++++++++++
 tb/tb_msu_data_port.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_data_port.sv
// MSU1 data port: CPU register window, seek handshake with the data store,
// and auto-incrementing read address with a prefetch-advance pulse.
module msu_data_port #(
  parameter int NEXT_HOLD = 4,
  parameter int SEEK_HOLD = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [2:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic [6:0]  status_lo,
  output logic        data_busy,
  output logic [31:0] rd_addr,
  output logic        rd_seek,
  input  logic        rd_seek_done,
  output logic        rd_next,
  input  logic [7:0]  rd_dout
);

  typedef enum logic [1:0] {IDLE, SEEK_REQ, SEEK_WAIT} state_t;

  localparam logic [15:0] SeekLast = 16'(SEEK_HOLD - 1);
  localparam logic [15:0] NextLast = 16'(NEXT_HOLD - 1);

  state_t      state_q;
  logic [31:0] seek_reg_q;
  logic [31:0] seek_reg_d;
  logic        sync1_q;
  logic        done_s_q;
  logic [31:0] rd_addr_q;
  logic        rd_seek_q;
  logic        data_busy_q;
  logic        rd_next_q;
  logic        pending_q;
  logic [31:0] pend_tgt_q;
  logic [15:0] seek_cnt_q;
  logic [15:0] next_cnt_q;

  logic        seek_req;
  logic [31:0] seek_tgt;
  logic        seek_start;
  logic [31:0] start_tgt;
  logic        rd_inc;
  logic [31:0] addr_inc;

  // The target of an offset-3 write is the shadow with the new top byte merged in.
  always_comb begin
    seek_reg_d = seek_reg_q;
    if (cpu_wr && !cpu_addr[2]) begin
      case (cpu_addr[1:0])
        2'd0:    seek_reg_d[7:0]   = cpu_din;
        2'd1:    seek_reg_d[15:8]  = cpu_din;
        2'd2:    seek_reg_d[23:16] = cpu_din;
        default: seek_reg_d[31:24] = cpu_din;
      endcase
    end
  end

  assign seek_req = cpu_wr && (cpu_addr == 3'd3);
  assign seek_tgt = seek_reg_d;
  assign rd_inc   = cpu_rd && (cpu_addr == 3'd1) && !data_busy_q;
  assign addr_inc = rd_addr_q + 32'd1;

  // A fresh write always beats a previously latched pending target.
  assign seek_start = ((state_q == IDLE) && seek_req) ||
                      ((state_q == SEEK_WAIT) && done_s_q && (seek_req || pending_q));
  assign start_tgt  = seek_req ? seek_tgt : pend_tgt_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      seek_reg_q  <= '0;
      sync1_q     <= 1'b0;
      done_s_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_seek_q   <= 1'b0;
      data_busy_q <= 1'b0;
      rd_next_q   <= 1'b0;
      pending_q   <= 1'b0;
      pend_tgt_q  <= '0;
      seek_cnt_q  <= '0;
      next_cnt_q  <= '0;
    end else begin
      seek_reg_q <= seek_reg_d;
      sync1_q    <= rd_seek_done;
      done_s_q   <= sync1_q;
      if (seek_start) begin
        rd_addr_q   <= start_tgt;
        rd_seek_q   <= 1'b1;
        data_busy_q <= 1'b1;
        seek_cnt_q  <= '0;
        pending_q   <= 1'b0;
        rd_next_q   <= 1'b0;
        next_cnt_q  <= '0;
        state_q     <= SEEK_REQ;
      end else begin
        case (state_q)
          // Hold the request until the store has dropped its previous done level.
          SEEK_REQ: begin
            if ((seek_cnt_q >= SeekLast) && !done_s_q) begin
              rd_seek_q <= 1'b0;
              state_q   <= SEEK_WAIT;
            end else if (seek_cnt_q < SeekLast) begin
              seek_cnt_q <= seek_cnt_q + 16'd1;
            end
          end
          SEEK_WAIT: begin
            if (done_s_q) begin
              data_busy_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
          default: ;
        endcase
        if (seek_req && (state_q != IDLE)) begin
          pending_q  <= 1'b1;
          pend_tgt_q <= seek_tgt;
        end
        if (rd_inc) begin
          rd_addr_q <= addr_inc;
        end
        if (rd_inc && (addr_inc[2:0] == 3'd0)) begin
          rd_next_q  <= 1'b1;
          next_cnt_q <= '0;
        end else if (rd_next_q) begin
          if (next_cnt_q >= NextLast) begin
            rd_next_q  <= 1'b0;
            next_cnt_q <= '0;
          end else begin
            next_cnt_q <= next_cnt_q + 16'd1;
          end
        end
      end
    end
  end

  always_comb begin
    cpu_dout = 8'h00;
    case (cpu_addr)
      3'd0:    cpu_dout = {data_busy_q, status_lo};
      3'd1:    cpu_dout = data_busy_q ? 8'h00 : rd_dout;
      3'd2:    cpu_dout = 8'h53;
      3'd3:    cpu_dout = 8'h2D;
      3'd4:    cpu_dout = 8'h4D;
      3'd5:    cpu_dout = 8'h53;
      3'd6:    cpu_dout = 8'h55;
      default: cpu_dout = 8'h31;
    endcase
  end

  assign data_busy = data_busy_q;
  assign rd_addr   = rd_addr_q;
  assign rd_seek   = rd_seek_q;
  assign rd_next   = rd_next_q;

endmodule

// File: tb/tb_msu_data_port.sv
// Bench for msu_data_port: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_msu_data_port;

  localparam int NextHold = 4;
  localparam int SeekHold = 8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [2:0]  cpu_addr;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic [6:0]  status_lo;
  logic        data_busy;
  logic [31:0] rd_addr;
  logic        rd_seek;
  logic        storeDone = 1'b1;
  logic        rd_next;
  logic [7:0]  rd_dout;

  int checks = 0;
  int errors = 0;

  msu_data_port #(.NEXT_HOLD(NextHold), .SEEK_HOLD(SeekHold)) dut (
    .clk_sys(clk_sys), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_rd(cpu_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .status_lo(status_lo),
    .data_busy(data_busy), .rd_addr(rd_addr), .rd_seek(rd_seek),
    .rd_seek_done(storeDone), .rd_next(rd_next), .rd_dout(rd_dout)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] storeByte(input logic [31:0] a);
    return a[7:0] ^ a[31:24] ^ 8'h5A;
  endfunction

  assign rd_dout = storeByte(rd_addr);

  // Data store: drops done when it sees a seek, raises it some cycles after the seek ends.
  int storeDly = 0;
  bit directedMode = 1'b1;
  always @(negedge clk_sys) begin
    if (rd_seek === 1'b1) begin
      if (storeDone) begin
        storeDone = 1'b0;
        storeDly  = directedMode ? 6 : int'($urandom_range(0, 5));
      end
    end else if (!storeDone) begin
      if (storeDly == 0) storeDone = 1'b1;
      else storeDly--;
    end
  end

  // Reference model: phase is implied by (busy, seek); counters count cycles remaining/elapsed.
  bit          modelOn = 1'b0;
  logic [31:0] m_seekreg, m_addr, m_pendTgt, newReg;
  logic        m_busy, m_seek, m_pend, h1, h2;
  int          m_seekCycles, m_nextLeft;
  logic        wr3, inc, start, ds, oldBusy;
  logic [7:0]  idStr [0:7] = '{8'h00, 8'h00, 8'h53, 8'h2D, 8'h4D, 8'h53, 8'h55, 8'h31};

  always @(posedge clk_sys) begin
    if (reset) begin
      m_seekreg = '0; m_addr = '0; m_pendTgt = '0;
      m_busy = 0; m_seek = 0; m_pend = 0; h1 = 0; h2 = 0;
      m_seekCycles = 0; m_nextLeft = 0;
      modelOn = 1'b1;
    end else if (modelOn) begin
      ds = h2;
      oldBusy = m_busy;
      newReg = m_seekreg;
      if (cpu_wr && cpu_addr < 3'd4) newReg[8*cpu_addr[1:0] +: 8] = cpu_din;
      wr3 = cpu_wr && (cpu_addr == 3'd3);
      inc = cpu_rd && (cpu_addr == 3'd1) && !m_busy;
      start = (!m_busy && wr3) || (m_busy && !m_seek && ds && (wr3 || m_pend));
      if (start) begin
        m_addr = wr3 ? newReg : m_pendTgt;
        m_seek = 1; m_busy = 1; m_seekCycles = 1; m_pend = 0; m_nextLeft = 0;
      end else begin
        if (m_busy && m_seek) begin
          if (m_seekCycles >= SeekHold && !ds) m_seek = 0;
          else m_seekCycles++;
        end else if (m_busy && ds) begin
          m_busy = 0;
        end
        if (wr3 && oldBusy) begin
          m_pend = 1; m_pendTgt = newReg;
        end
        if (inc) begin
          m_addr = m_addr + 32'd1;
          if (m_addr[2:0] == 3'd0) m_nextLeft = NextHold;
          else if (m_nextLeft > 0) m_nextLeft--;
        end else if (m_nextLeft > 0) begin
          m_nextLeft--;
        end
      end
      m_seekreg = newReg;
      h2 = h1;
      h1 = storeDone;
    end
  end

  function automatic logic [7:0] modelDout(input logic [2:0] a);
    if (a == 3'd0) return {m_busy, status_lo};
    if (a == 3'd1) return m_busy ? 8'h00 : storeByte(m_addr);
    return idStr[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    #2;
    if (modelOn && !reset) begin
      checkOutput("model rd_addr", rd_addr, m_addr);
      checkOutput("model data_busy", 32'(data_busy), 32'(m_busy));
      checkOutput("model rd_seek", 32'(rd_seek), 32'(m_seek));
      checkOutput("model rd_next", 32'(rd_next), 32'(m_nextLeft > 0));
      checkOutput("model cpu_dout", 32'(cpu_dout), 32'(modelDout(cpu_addr)));
    end
  end

  task automatic applyStimulus(input logic rst, input logic wr, input logic rd,
                               input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    reset = rst; cpu_wr = wr; cpu_rd = rd; cpu_addr = a; cpu_din = d;
    #3;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic writeSeek(input logic [31:0] t);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 3'(i), t[8*i +: 8]);
    idle();
  endtask

  task automatic waitIdle();
    int n = 0;
    while (data_busy !== 1'b0 && n < 400) begin
      idle();
      n++;
    end
    if (n >= 400) checkOutput("waitIdle timeout", 32'(data_busy), 32'd0);
  endtask

  initial begin
    int cnt;
    int rises;
    logic prevSeek;
    logic [31:0] seekAddr;
    logic [2:0] a;
    logic wr, rd;

    reset = 1; cpu_wr = 0; cpu_rd = 0; cpu_addr = 0; cpu_din = 0; status_lo = 0;
    repeat (3) applyStimulus(1, 0, 0, 3'd0, 8'h00);
    applyStimulus(0, 0, 0, 3'd2, 8'h00);
    checkOutput("reset rd_addr", rd_addr, 32'd0);
    checkOutput("reset data_busy", 32'(data_busy), 32'd0);
    checkOutput("reset rd_seek", 32'(rd_seek), 32'd0);
    checkOutput("reset rd_next", 32'(rd_next), 32'd0);
    checkOutput("reset id byte", 32'(cpu_dout), 32'h53);

    // Little-endian seek load and minimum seek hold.
    applyStimulus(0, 1, 0, 3'd0, 8'h78);
    applyStimulus(0, 1, 0, 3'd1, 8'h56);
    applyStimulus(0, 1, 0, 3'd2, 8'h34);
    applyStimulus(0, 1, 0, 3'd3, 8'h12);
    idle();
    checkOutput("seek target", rd_addr, 32'h12345678);
    checkOutput("seek busy", 32'(data_busy), 32'd1);
    cnt = 0;
    while (rd_seek === 1'b1 && cnt < 100) begin cnt++; idle(); end
    checkOutput("seek hold >= 8", 32'(cnt >= 8 && cnt < 100), 32'd1);
    waitIdle();

    // Increment and prefetch pulse on the 7->8 step.
    writeSeek(32'h00000006);
    waitIdle();
    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    idle();
    checkOutput("read1 addr", rd_addr, 32'd7);
    checkOutput("read1 next", 32'(rd_next), 32'd0);
    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    idle();
    checkOutput("read2 addr", rd_addr, 32'd8);
    cnt = 0;
    while (rd_next === 1'b1 && cnt < 20) begin cnt++; idle(); end
    checkOutput("next pulse length", cnt, 32'd4);
    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    idle();
    checkOutput("read3 addr", rd_addr, 32'd9);
    checkOutput("read3 next", 32'(rd_next), 32'd0);

    // Reads while busy are blocked; status byte shows busy.
    applyStimulus(0, 1, 0, 3'd3, 8'h00);
    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    checkOutput("busy read dout", 32'(cpu_dout), 32'h00);
    idle();
    checkOutput("busy read addr", rd_addr, 32'd6);
    checkOutput("busy read next", 32'(rd_next), 32'd0);
    status_lo = 7'h01;
    idle();
    checkOutput("busy status", 32'(cpu_dout), 32'h81);

    // Second seek during the wait phase chains into one continuous busy period.
    cnt = 0;
    while (!(data_busy === 1'b1 && rd_seek === 1'b0) && cnt < 100) begin cnt++; idle(); end
    checkOutput("reach seek wait", 32'(cnt < 100), 32'd1);
    applyStimulus(0, 1, 0, 3'd3, 8'h40);
    prevSeek = rd_seek; rises = 0; seekAddr = '0; cnt = 0;
    while (cnt < 400) begin
      idle();
      cnt++;
      if (rd_seek === 1'b1 && !prevSeek) begin rises++; seekAddr = rd_addr; end
      prevSeek = rd_seek;
      if (data_busy !== 1'b1) break;
    end
    checkOutput("chain timeout", 32'(cnt < 400), 32'd1);
    checkOutput("chain seek count", rises, 32'd1);
    checkOutput("chain target", seekAddr, 32'h40000006);
    cnt = 0;
    repeat (10) begin idle(); if (data_busy !== 1'b0 || rd_seek !== 1'b0) cnt++; end
    checkOutput("single completion", cnt, 32'd0);

    // Address wrap.
    writeSeek(32'hFFFFFFFF);
    waitIdle();
    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    idle();
    checkOutput("wrap addr", rd_addr, 32'd0);
    checkOutput("wrap next", 32'(rd_next), 32'd1);

    for (int i = 2; i < 8; i++) begin
      applyStimulus(0, 0, 0, 3'(i), 8'h00);
      checkOutput("id string", 32'(cpu_dout), 32'(idStr[i]));
    end

    // Reset during an active seek.
    writeSeek(32'h00000100);
    checkOutput("pre-reset seek", 32'(rd_seek), 32'd1);
    applyStimulus(1, 0, 0, 3'd0, 8'h00);
    idle();
    checkOutput("mid-reset seek", 32'(rd_seek), 32'd0);
    checkOutput("mid-reset busy", 32'(data_busy), 32'd0);
    checkOutput("mid-reset addr", rd_addr, 32'd0);
    repeat (20) idle();

    directedMode = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      wr = ($urandom_range(0, 99) < 8);
      rd = ($urandom_range(0, 99) < 45);
      a = 3'($urandom_range(0, 7));
      if (wr && $urandom_range(0, 2) == 0) a = 3'd3;
      else if (!wr && rd && $urandom_range(0, 3) != 0) a = 3'd1;
      status_lo = 7'($urandom);
      applyStimulus(($urandom_range(0, 799) == 0), wr, rd, a,
                    ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
